// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// FSM state encoding and iteration-counter sizing.
package muldiv_pkg;

    localparam logic [5:0] FC_MFHI  = 6'h10;
    localparam logic [5:0] FC_MTHI  = 6'h11;
    localparam logic [5:0] FC_MFLO  = 6'h12;
    localparam logic [5:0] FC_MTLO  = 6'h13;
    localparam logic [5:0] FC_MULT  = 6'h18;
    localparam logic [5:0] FC_MULTU = 6'h19;
    localparam logic [5:0] FC_DIV   = 6'h1A;
    localparam logic [5:0] FC_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Counter holds 0..NB_REG-1 with a spare bit of headroom.
    function automatic int count_width(input int nb_reg);
        return $clog2(nb_reg) + 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc,q} pair: shift-add for multiply,
// restoring compare-subtract-shift for divide.
module muldiv_step #(
    parameter int NB_REG = 32
) (
    input  logic              i_is_div,
    input  logic [NB_REG-1:0] i_acc,
    input  logic [NB_REG-1:0] i_q,
    input  logic [NB_REG-1:0] i_opnd,
    output logic [NB_REG-1:0] o_acc,
    output logic [NB_REG-1:0] o_q
);

    logic [NB_REG:0] sum;
    logic [NB_REG:0] add_sel;
    logic [NB_REG:0] shifted;
    logic [NB_REG:0] diff;
    logic            borrow;

    always_comb begin
        sum     = {1'b0, i_acc} + {1'b0, i_opnd};
        add_sel = i_q[0] ? sum : {1'b0, i_acc};
        shifted = {i_acc, i_q[NB_REG-1]};
        diff    = shifted - {1'b0, i_opnd};
        // Partial remainder stays below the divisor, so the top bit of diff is a clean borrow.
        borrow  = diff[NB_REG];

        if (i_is_div) begin
            o_acc = borrow ? shifted[NB_REG-1:0] : diff[NB_REG-1:0];
            o_q   = {i_q[NB_REG-2:0], ~borrow};
        end else begin
            o_acc = add_sel[NB_REG:1];
            o_q   = {add_sel[0], i_q[NB_REG-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/DIV unit owning HI/LO, with MFHI/MFLO bypass and pipeline stall.
// Define MULDIV_DIV_EN to enable DIV/DIVU; otherwise they are accepted as no-ops.
module alu_muldiv
    import muldiv_pkg::*;
#(
    parameter int NB_REG   = 32,
    parameter int NB_FCODE = 6
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_FCODE-1:0] i_funct,
    input  logic [NB_REG-1:0]   i_A,
    input  logic [NB_REG-1:0]   i_B,
    input  logic                i_flush,
    output logic                o_ready,
    output logic                o_stall,
    output logic                o_done,
    output logic                o_div_zero,
    output logic [NB_REG-1:0]   o_result,
    output logic [NB_REG-1:0]   o_hi,
    output logic [NB_REG-1:0]   o_lo
);

    localparam int NB_COUNT = count_width(NB_REG);

    localparam logic [NB_FCODE-1:0] F_MFHI  = NB_FCODE'(FC_MFHI);
    localparam logic [NB_FCODE-1:0] F_MTHI  = NB_FCODE'(FC_MTHI);
    localparam logic [NB_FCODE-1:0] F_MFLO  = NB_FCODE'(FC_MFLO);
    localparam logic [NB_FCODE-1:0] F_MTLO  = NB_FCODE'(FC_MTLO);
    localparam logic [NB_FCODE-1:0] F_MULT  = NB_FCODE'(FC_MULT);
    localparam logic [NB_FCODE-1:0] F_MULTU = NB_FCODE'(FC_MULTU);
    localparam logic [NB_FCODE-1:0] F_DIV   = NB_FCODE'(FC_DIV);
    localparam logic [NB_FCODE-1:0] F_DIVU  = NB_FCODE'(FC_DIVU);

    state_e                state_q, state_d;
    logic [NB_COUNT-1:0]   count_q, count_d;
    logic [NB_REG-1:0]     acc_q, acc_d;
    logic [NB_REG-1:0]     q_q, q_d;
    logic [NB_REG-1:0]     opnd_q, opnd_d;
    logic [NB_REG-1:0]     hi_q, hi_d;
    logic [NB_REG-1:0]     lo_q, lo_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_q, neg_d;
    logic                  sign_a_q, sign_a_d;
    logic                  div_zero_q, div_zero_d;

    logic                  op_mfhi, op_mflo, op_mthi, op_mtlo, op_mult, op_div, op_signed;
    logic                  a_neg, b_neg;
    logic [NB_REG-1:0]     abs_a, abs_b;
    logic [NB_REG-1:0]     step_acc, step_q;
    logic [2*NB_REG-1:0]   prod;
    logic [NB_REG-1:0]     quo, rem;

    always_comb begin
        op_mfhi   = i_valid && (i_funct == F_MFHI);
        op_mflo   = i_valid && (i_funct == F_MFLO);
        op_mthi   = i_valid && (i_funct == F_MTHI);
        op_mtlo   = i_valid && (i_funct == F_MTLO);
        op_mult   = i_valid && ((i_funct == F_MULT) || (i_funct == F_MULTU));
        op_div    = i_valid && ((i_funct == F_DIV) || (i_funct == F_DIVU));
        op_signed = (i_funct == F_MULT) || (i_funct == F_DIV);
        a_neg     = op_signed && i_A[NB_REG-1];
        b_neg     = op_signed && i_B[NB_REG-1];
        abs_a     = a_neg ? -i_A : i_A;
        abs_b     = b_neg ? -i_B : i_B;
    end

    muldiv_step #(
        .NB_REG (NB_REG)
    ) u_step (
        .i_is_div (is_div_q),
        .i_acc    (acc_q),
        .i_q      (q_q),
        .i_opnd   (opnd_q),
        .o_acc    (step_acc),
        .o_q      (step_q)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            q_q        <= q_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            sign_a_q   <= sign_a_d;
            div_zero_q <= div_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        q_d        = q_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        sign_a_d   = sign_a_q;
        div_zero_d = div_zero_q;

        prod = {acc_q, q_q};
        if (neg_q) begin
            prod = -prod;
        end
        quo = neg_q ? -q_q : q_q;
        rem = sign_a_q ? -acc_q : acc_q;

        case (state_q)
            ST_IDLE: begin
                // A flushed instruction must leave no trace, including MTHI/MTLO.
                if (!i_flush) begin
                    if (op_mthi) hi_d = i_A;
                    if (op_mtlo) lo_d = i_A;
                    if (op_mult) begin
                        acc_d      = '0;
                        q_d        = abs_b;
                        opnd_d     = abs_a;
                        is_div_d   = 1'b0;
                        neg_d      = a_neg ^ b_neg;
                        sign_a_d   = a_neg;
                        div_zero_d = 1'b0;
                        count_d    = '0;
                        state_d    = ST_RUN;
                    end
`ifdef MULDIV_DIV_EN
                    if (op_div) begin
                        acc_d      = '0;
                        q_d        = abs_a;
                        opnd_d     = abs_b;
                        is_div_d   = 1'b1;
                        neg_d      = a_neg ^ b_neg;
                        sign_a_d   = a_neg;
                        div_zero_d = (abs_b == '0);
                        count_d    = '0;
                        state_d    = (abs_b == '0) ? ST_FIX : ST_RUN;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = step_acc;
                    q_d     = step_q;
                    count_d = count_q + NB_COUNT'(1);
                    if (count_q == NB_COUNT'(NB_REG - 1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                // q still holds |A| on a zero divisor, so re-signing it restores i_A.
                if (div_zero_q) begin
                    lo_d = '1;
                    hi_d = sign_a_q ? -q_q : q_q;
                end else if (is_div_q) begin
                    lo_d = quo;
                    hi_d = rem;
                end else begin
                    hi_d = prod[2*NB_REG-1:NB_REG];
                    lo_d = prod[NB_REG-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_stall = 1'b0;
        case (state_q)
            ST_RUN:  o_stall = op_mfhi | op_mflo | op_mthi | op_mtlo | op_mult | op_div;
            ST_FIX:  o_stall = op_mthi | op_mtlo | op_mult | op_div;
            default: o_stall = 1'b0;
        endcase
    end

    assign o_ready    = (state_q == ST_IDLE);
    assign o_done     = (state_q == ST_FIX);
    assign o_div_zero = (state_q == ST_FIX) && div_zero_q;
    assign o_result   = op_mfhi ? hi_d : (op_mflo ? lo_d : '0);
    assign o_hi       = hi_q;
    assign o_lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: cycle-level reference model plus directed and random stimulus.
module tb_alu_muldiv;

    localparam logic [5:0] MFHI  = 6'h10;
    localparam logic [5:0] MTHI  = 6'h11;
    localparam logic [5:0] MFLO  = 6'h12;
    localparam logic [5:0] MTLO  = 6'h13;
    localparam logic [5:0] MULT  = 6'h18;
    localparam logic [5:0] MULTU = 6'h19;
    localparam logic [5:0] DIV   = 6'h1A;
    localparam logic [5:0] DIVU  = 6'h1B;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid   = 1'b0;
    logic [5:0]  funct   = 6'h0;
    logic [31:0] opa     = 32'h0;
    logic [31:0] opb     = 32'h0;
    logic        flush   = 1'b0;
    logic        ready, stall, done, div_zero;
    logic [31:0] result, hi, lo;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_pend, m_pdz;
    int          m_wait;

    always #5 clock = ~clock;

    alu_muldiv #(
        .NB_REG   (32),
        .NB_FCODE (6)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset_n),
        .i_valid    (valid),
        .i_funct    (funct),
        .i_A        (opa),
        .i_B        (opb),
        .i_flush    (flush),
        .o_ready    (ready),
        .o_stall    (stall),
        .o_done     (done),
        .o_div_zero (div_zero),
        .o_result   (result),
        .o_hi       (hi),
        .o_lo       (lo)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic fl);
        valid = v;
        funct = f;
        opa   = a;
        opb   = b;
        flush = fl;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] multRef(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    // Returns {HI, LO}: remainder in HI, quotient in LO.
    function automatic logic [63:0] divRef(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Reference model: evaluated each negedge against the inputs that the next posedge will see.
    always @(negedge clock) begin
        logic        in_fix, running, exp_stall;
        logic [31:0] exp_res;
        logic [63:0] r;
        if (!reset_n) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_pdz = 0; m_wait = 0; m_phi = 0; m_plo = 0;
        end
        in_fix  = m_pend && (m_wait == 0);
        running = m_pend && (m_wait > 0);
        exp_stall = 1'b0;
        if (running && valid && (funct inside {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU}))
            exp_stall = 1'b1;
        if (in_fix && valid && (funct inside {MTHI, MTLO, MULT, MULTU, DIV, DIVU}))
            exp_stall = 1'b1;
        exp_res = 32'h0;
        if (valid && funct == MFHI) exp_res = in_fix ? m_phi : m_hi;
        if (valid && funct == MFLO) exp_res = in_fix ? m_plo : m_lo;

        checkOutput("ready",    {31'h0, ready},    {31'h0, !m_pend});
        checkOutput("done",     {31'h0, done},     {31'h0, in_fix});
        checkOutput("div_zero", {31'h0, div_zero}, {31'h0, in_fix && m_pdz});
        checkOutput("stall",    {31'h0, stall},    {31'h0, exp_stall});
        checkOutput("hi",       hi,     m_hi);
        checkOutput("lo",       lo,     m_lo);
        checkOutput("result",   result, exp_res);

        if (reset_n) begin
            if (in_fix) begin
                m_hi   = m_phi;
                m_lo   = m_plo;
                m_pend = 0;
            end else if (running) begin
                if (flush) m_pend = 0;
                else       m_wait--;
            end else if (valid && !flush) begin
                if (funct == MTHI) m_hi = opa;
                if (funct == MTLO) m_lo = opa;
                if (funct == MULT || funct == MULTU) begin
                    r = multRef(funct == MULT, opa, opb);
                    {m_phi, m_plo} = r;
                    m_pdz  = 0;
                    m_pend = 1;
                    m_wait = 32;
                end
`ifdef MULDIV_DIV_EN
                if (funct == DIV || funct == DIVU) begin
                    r = divRef(funct == DIV, opa, opb);
                    {m_phi, m_plo} = r;
                    m_pdz  = (opb == 32'h0);
                    m_pend = 1;
                    m_wait = (opb == 32'h0) ? 0 : 32;
                end
`endif
            end
        end
    end

    // Issues one op, then returns edges from accept to the HI/LO write (-1 if o_done never came).
    task automatic runOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic dz);
        applyStimulus(1'b1, f, a, b, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        edges = -1;
        dz    = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (done) begin
                edges = n + 1;
                dz    = div_zero;
                break;
            end
            @(posedge clock);
        end
        nextCycle();
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] r;
        logic [5:0]  fcodes [8];
        int          edges, stalls, dones;
        logic        dz;
        fcodes = '{MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU};

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_ready", {31'h0, ready}, 32'h1);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        reset_n = 1'b1;

        r = multRef(1'b1, 32'hFFFFFFFE, 32'h3);
        checkOutput("model_mult_hi", r[63:32], 32'hFFFFFFFF);
        checkOutput("model_mult_lo", r[31:0],  32'hFFFFFFFA);
        r = multRef(1'b0, 32'hFFFFFFFE, 32'h3);
        checkOutput("model_multu_hi", r[63:32], 32'h00000002);
        r = divRef(1'b1, 32'hFFFFFFF9, 32'h2);
        checkOutput("model_div_lo", r[31:0],  32'hFFFFFFFD);
        checkOutput("model_div_hi", r[63:32], 32'hFFFFFFFF);
        r = divRef(1'b1, 32'h80000000, 32'hFFFFFFFF);
        checkOutput("model_divmin_lo", r[31:0], 32'h80000000);
        checkOutput("model_divmin_hi", r[63:32], 32'h0);

        nextCycle();
        applyStimulus(1'b1, MTHI, 32'h1234, 32'h0, 1'b0); nextCycle();
        applyStimulus(1'b1, MTLO, 32'h5678, 32'h0, 1'b0); nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("mthi_hi", hi, 32'h1234);
        checkOutput("mtlo_lo", lo, 32'h5678);

        runOp(MULT, 32'hFFFFFFFE, 32'h3, edges, dz);
        checkOutput("mult_latency", 32'(edges), 32'd33);
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFA);

        runOp(MULTU, 32'hFFFFFFFE, 32'h3, edges, dz);
        checkOutput("multu_hi", hi, 32'h00000002);
        checkOutput("multu_lo", lo, 32'hFFFFFFFA);

`ifdef MULDIV_DIV_EN
        runOp(DIV, 32'hFFFFFFF9, 32'h2, edges, dz);
        checkOutput("div_latency", 32'(edges), 32'd33);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        checkOutput("div_hi", hi, 32'hFFFFFFFF);
        runOp(DIVU, 32'h7, 32'h0, edges, dz);
        checkOutput("divz_latency", 32'(edges), 32'd1);
        checkOutput("divz_flag", {31'h0, dz}, 32'h1);
        checkOutput("divz_lo", lo, 32'hFFFFFFFF);
        checkOutput("divz_hi", hi, 32'h7);
        runOp(DIV, 32'h80000000, 32'hFFFFFFFF, edges, dz);
        checkOutput("divmin_lo", lo, 32'h80000000);
        checkOutput("divmin_hi", hi, 32'h0);
`else
        applyStimulus(1'b1, DIV, 32'hFFFFFFF9, 32'h2, 1'b0); nextCycle();
        applyStimulus(1'b1, DIVU, 32'h7, 32'h0, 1'b0); nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || div_zero) dones++;
        end
        nextCycle();
        checkOutput("nodiv_dones", 32'(dones), 32'd0);
        checkOutput("nodiv_hi", hi, 32'h00000002);
        checkOutput("nodiv_lo", lo, 32'hFFFFFFFA);
`endif

        applyStimulus(1'b1, MULT, 32'h5, 32'h7, 1'b0); nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0); nextCycle();
        applyStimulus(1'b1, MFLO, 32'h0, 32'h0, 1'b0);
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!stall) break;
            stalls++;
            @(posedge clock);
        end
        checkOutput("mflo_stall_cycles", 32'(stalls), 32'd31);
        checkOutput("mflo_bypass", result, 32'd35);
        checkOutput("mflo_done", {31'h0, done}, 32'h1);
        nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);

        applyStimulus(1'b1, MTHI, 32'h1234, 32'h0, 1'b0); nextCycle();
        applyStimulus(1'b1, MTLO, 32'h5678, 32'h0, 1'b0); nextCycle();
        applyStimulus(1'b1, MULT, 32'hFFFFFFFE, 32'h3, 1'b0); nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        repeat (9) nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b1); nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        nextCycle();
        checkOutput("flush_dones", 32'(dones), 32'd0);
        checkOutput("flush_hi", hi, 32'h1234);
        checkOutput("flush_lo", lo, 32'h5678);
        checkOutput("flush_ready", {31'h0, ready}, 32'h1);

        applyStimulus(1'b1, DIV, 32'd100, 32'd3, 1'b0); nextCycle();
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        repeat (5) nextCycle();
        reset_n = 1'b0;
        #2;
        checkOutput("midreset_hi", hi, 32'h0);
        checkOutput("midreset_lo", lo, 32'h0);
        checkOutput("midreset_ready", {31'h0, ready}, 32'h1);
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] f;
            case ($urandom_range(0, 9))
                8:       f = 6'h20;
                9:       f = 6'($urandom_range(0, 63));
                default: f = fcodes[$urandom_range(0, 7)];
            endcase
            applyStimulus(1'($urandom_range(0, 1)), f, randOperand(), randOperand(),
                          ($urandom_range(0, 31) == 0));
            nextCycle();
        end
        applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 1'b0);
        repeat (40) nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
